// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types and constants for the EX/MEM pipeline stage.
//   DATA_W / REG_W  : datapath and register-index widths
//   ex_mem_state_e  : stage state encoding (EMPTY, FULL, SKID)
//   ex_mem_payload_t: packed EX/MEM beat carried through the stage
//   pcSrcOf()       : branch-taken decode of a held beat
package ex_mem_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b10
  } ex_mem_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] busW;
    logic [DATA_W-1:0] busB;
    logic [REG_W-1:0]  rd;
    logic              memRead;
    logic              memWrite;
    logic              memtoReg;
    logic              regWrite;
    logic              branch;
    logic              zero;
  } ex_mem_payload_t;

  function automatic logic pcSrcOf(input ex_mem_payload_t p);
    return p.branch & p.zero;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: EX-side input beat, MEM-side output beat and flush for the
// EX/MEM stage.
//   slave  : the stage's view (consumes in_* / out_ready / flush, drives
//            in_ready / out_valid / *_out / PCSrc)
//   master : the surrounding pipeline's view (opposite directions)
interface ex_mem_stage_if;
  import ex_mem_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] BusW_in;
  logic              Zero_in;
  logic [DATA_W-1:0] BusB_in;
  logic [REG_W-1:0]  Rd_in;
  logic              MemRead_in;
  logic              MemWrite_in;
  logic              MemtoReg_in;
  logic              RegWrite_in;
  logic              Branch_in;
  logic              flush;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] BusW_out;
  logic [DATA_W-1:0] BusB_out;
  logic [REG_W-1:0]  Rd_out;
  logic              MemRead_out;
  logic              MemWrite_out;
  logic              MemtoReg_out;
  logic              RegWrite_out;
  logic              PCSrc;

  modport slave (
    input  in_valid, BusW_in, Zero_in, BusB_in, Rd_in,
           MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in, Branch_in,
           flush, out_ready,
    output in_ready, out_valid, BusW_out, BusB_out, Rd_out,
           MemRead_out, MemWrite_out, MemtoReg_out, RegWrite_out, PCSrc
  );

  modport master (
    output in_valid, BusW_in, Zero_in, BusB_in, Rd_in,
           MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in, Branch_in,
           flush, out_ready,
    input  in_ready, out_valid, BusW_out, BusB_out, Rd_out,
           MemRead_out, MemWrite_out, MemtoReg_out, RegWrite_out, PCSrc
  );

endinterface

// File: rtl/ex_mem_payload_reg.sv
// ex_mem_payload_reg: enable-loaded EX/MEM payload register with synchronous
// active-low clear.
//   clk  : rising-edge clock
//   rstN : synchronous active-low reset, clears the payload to zero
//   en   : load d on the next edge
//   d    : payload in
//   q    : held payload
module ex_mem_payload_reg
  import ex_mem_pkg::*;
(
  input  logic            clk,
  input  logic            rstN,
  input  logic            en,
  input  ex_mem_payload_t d,
  output ex_mem_payload_t q
);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with valid/ready handshake on both
// sides, 1-cycle latency and full throughput.
//   CLK     : rising-edge clock
//   Reset_L : synchronous active-low reset
//   bus     : ex_mem_stage_if.slave -- EX input beat, MEM output beat, flush
// Build option EX_MEM_SKID_EN: adds a 1-entry skid register and SKID state so
// in_ready is a flop (state != SKID); without it in_ready is the combinational
// (!out_valid | out_ready) and the stage holds at most one beat.
module ex_mem_stage
  import ex_mem_pkg::*;
(
  input  logic           CLK,
  input  logic           Reset_L,
  ex_mem_stage_if.slave  bus
);

  ex_mem_state_e   state;
  ex_mem_state_e   nextState;
  logic            outValid;
  logic            inReady;
  logic            accept;
  logic            drain;
  logic            outLoad;
  ex_mem_payload_t inPayload;
  ex_mem_payload_t outD;
  ex_mem_payload_t outQ;

  assign outValid = (state != EMPTY);
  assign accept   = bus.in_valid & inReady;
  assign drain    = outValid & bus.out_ready;

  assign inPayload = '{
    busW:     bus.BusW_in,
    busB:     bus.BusB_in,
    rd:       bus.Rd_in,
    memRead:  bus.MemRead_in,
    memWrite: bus.MemWrite_in,
    memtoReg: bus.MemtoReg_in,
    regWrite: bus.RegWrite_in,
    branch:   bus.Branch_in,
    zero:     bus.Zero_in
  };

  // State register
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; flush overrides every other event
  always_comb begin
    nextState = state;
    if (bus.flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) nextState = FULL;
        end
        FULL: begin
`ifdef EX_MEM_SKID_EN
          if (accept && !drain)      nextState = SKID;
          else if (!accept && drain) nextState = EMPTY;
`else
          if (!accept && drain) nextState = EMPTY;
`endif
        end
`ifdef EX_MEM_SKID_EN
        SKID: begin
          if (drain) nextState = FULL;
        end
`endif
        default: nextState = EMPTY;
      endcase
    end
  end

`ifdef EX_MEM_SKID_EN
  logic            skidLoad;
  logic            selSkid;
  logic            inReadyQ;
  ex_mem_payload_t skidQ;

  // Output logic: register load enables and output-register source select
  always_comb begin
    outLoad  = 1'b0;
    skidLoad = 1'b0;
    selSkid  = 1'b0;
    if (!bus.flush) begin
      case (state)
        EMPTY: outLoad = accept;
        FULL: begin
          outLoad  = accept & drain;
          skidLoad = accept & ~drain;
        end
        SKID: begin
          outLoad = drain;
          selSkid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered from nextState so it lines up with the state it describes.
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      inReadyQ <= 1'b0;
    end else begin
      inReadyQ <= (nextState != SKID);
    end
  end

  assign inReady = inReadyQ;
  assign outD    = selSkid ? skidQ : inPayload;

  ex_mem_payload_reg uSkidReg (
    .clk  (CLK),
    .rstN (Reset_L),
    .en   (skidLoad),
    .d    (inPayload),
    .q    (skidQ)
  );
`else
  logic rstDoneQ;

  // Output logic: in FULL an accept implies a same-cycle drain, so the output
  // register simply loads on every accepted beat.
  always_comb begin
    outLoad = 1'b0;
    if (!bus.flush) begin
      outLoad = accept;
    end
  end

  // Holds in_ready low through the reset cycle, when out_valid is already 0.
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      rstDoneQ <= 1'b0;
    end else begin
      rstDoneQ <= 1'b1;
    end
  end

  assign inReady = rstDoneQ & (~outValid | bus.out_ready);
  assign outD    = inPayload;
`endif

  ex_mem_payload_reg uOutReg (
    .clk  (CLK),
    .rstN (Reset_L),
    .en   (outLoad),
    .d    (outD),
    .q    (outQ)
  );

  assign bus.in_ready     = inReady;
  assign bus.out_valid    = outValid;
  assign bus.BusW_out     = outQ.busW;
  assign bus.BusB_out     = outQ.busB;
  assign bus.Rd_out       = outQ.rd;
  assign bus.MemRead_out  = outQ.memRead;
  assign bus.MemWrite_out = outQ.memWrite;
  assign bus.MemtoReg_out = outQ.memtoReg;
  assign bus.RegWrite_out = outQ.regWrite;
  assign bus.PCSrc        = outValid & pcSrcOf(outQ);

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed self-checking bench for ex_mem_stage. Works with
// or without EX_MEM_SKID_EN; only the input-side driving of a stalled beat
// differs between builds.
module tb_ex_mem_stage;

  logic CLK;
  logic Reset_L;
  int   checks;
  int   errors;
  logic [63:0] outLog[$];
  int   logBase;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .bus     (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  // Record every delivered MEM beat, sampled mid-cycle.
  always @(negedge CLK) begin
    if (Reset_L === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      outLog.push_back(bus.BusW_out);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setBeat(input logic [63:0] w, input logic [4:0] rd,
                         input logic br, input logic z);
    bus.BusW_in     = w;
    bus.BusB_in     = ~w;
    bus.Rd_in       = rd;
    bus.MemRead_in  = w[0];
    bus.MemWrite_in = w[1];
    bus.MemtoReg_in = w[2];
    bus.RegWrite_in = 1'b1;
    bus.Branch_in   = br;
    bus.Zero_in     = z;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset_L       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    setBeat(64'h0, 5'd0, 1'b0, 1'b0);
    bus.RegWrite_in = 1'b0;

    // Reset state
    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_pcsrc",     bus.PCSrc, 0);
    check("rst_busw",      bus.BusW_out, 0);
    check("rst_rd",        bus.Rd_out, 0);
    check("rst_in_ready",  bus.in_ready, 0);
    Reset_L = 1'b1;
    step();
    check("rel_in_ready",  bus.in_ready, 1);

    // Single beat
    setBeat(64'h10, 5'd5, 1'b0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("one_valid",    bus.out_valid, 1);
    check("one_busw",     bus.BusW_out, 64'h10);
    check("one_busb",     bus.BusB_out, ~64'h10);
    check("one_rd",       bus.Rd_out, 5);
    check("one_regwrite", bus.RegWrite_out, 1);
    check("one_pcsrc",    bus.PCSrc, 0);
    step();
    check("one_empty",    bus.out_valid, 0);

    // PCSrc decode and gating
    setBeat(64'h20, 5'd1, 1'b1, 1'b1);
    bus.in_valid = 1'b1;
    step();
    check("br_taken",     bus.PCSrc, 1);
    setBeat(64'h21, 5'd2, 1'b1, 1'b0);
    step();
    check("br_nt_busw",   bus.BusW_out, 64'h21);
    check("br_not_taken", bus.PCSrc, 0);
    setBeat(64'h22, 5'd3, 1'b1, 1'b1);
    step();
    check("br_taken2",    bus.PCSrc, 1);
    bus.in_valid = 1'b0;
    step();
    check("br_gate_valid", bus.out_valid, 0);
    check("br_gate_pcsrc", bus.PCSrc, 0);

    // Backpressure: A held, B waits (in skid or at the input), then A, B
    logBase = outLog.size();
    bus.out_ready = 1'b0;
    setBeat(64'h30, 5'd6, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    step();
    setBeat(64'h31, 5'd7, 1'b0, 1'b0);
    check("bp_valid1", bus.out_valid, 1);
    check("bp_busw1",  bus.BusW_out, 64'h30);
    step();
    check("bp_busw2",  bus.BusW_out, 64'h30);
    check("bp_ready2", bus.in_ready, 0);
`ifdef EX_MEM_SKID_EN
    bus.in_valid = 1'b0;
`endif
    step();
    check("bp_busw3",  bus.BusW_out, 64'h30);
    check("bp_rd3",    bus.Rd_out, 6);
    check("bp_ready3", bus.in_ready, 0);
    check("bp_valid3", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("bp_valid4", bus.out_valid, 1);
    check("bp_busw4",  bus.BusW_out, 64'h31);
    check("bp_rd4",    bus.Rd_out, 7);
    step();
    check("bp_empty",  bus.out_valid, 0);
    check("bp_count",  outLog.size() - logBase, 2);
    check("bp_ord0",   outLog[logBase], 64'h30);
    check("bp_ord1",   outLog[logBase + 1], 64'h31);

    // Streaming: 8 back-to-back beats, no bubbles
    logBase = outLog.size();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      setBeat(64'h100 + 64'(i), 5'(i), 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      step();
      check("st_valid", bus.out_valid, 1);
      check("st_busw",  bus.BusW_out, 64'h100 + 64'(i));
    end
    bus.in_valid = 1'b0;
    step();
    check("st_empty", bus.out_valid, 0);
    check("st_count", outLog.size() - logBase, 8);
    for (int i = 0; i < 8; i++)
      check("st_order", outLog[logBase + i], 64'h100 + 64'(i));

    // Flush with the stage stalled full and a third beat offered
    logBase = outLog.size();
    bus.out_ready = 1'b0;
    setBeat(64'h40, 5'd8, 1'b1, 1'b1);
    bus.in_valid = 1'b1;
    step();
    setBeat(64'h41, 5'd9, 1'b0, 1'b0);
    step();
    setBeat(64'h42, 5'd10, 1'b0, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_valid",    bus.out_valid, 0);
    check("fl_pcsrc",    bus.PCSrc, 0);
    check("fl_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    step();
    step();
    check("fl_valid2",   bus.out_valid, 0);
    check("fl_none_out", outLog.size() - logBase, 0);

    // Reset while FULL and stalled
    logBase = outLog.size();
    bus.out_ready = 1'b0;
    setBeat(64'h50, 5'd11, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("rf_valid", bus.out_valid, 1);
    check("rf_busw",  bus.BusW_out, 64'h50);
    Reset_L = 1'b0;
    step();
    bus.out_ready = 1'b1;
    check("rf_rst_valid",    bus.out_valid, 0);
    check("rf_rst_busw",     bus.BusW_out, 0);
    check("rf_rst_in_ready", bus.in_ready, 0);
    Reset_L = 1'b1;
    step();
    check("rf_rel_in_ready", bus.in_ready, 1);
    check("rf_rel_valid",    bus.out_valid, 0);
    check("rf_none_out",     outLog.size() - logBase, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Reset and clock SHALL be one clock, CLK, and reset SHALL be synchronous and active-low, Reset_L.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 Reset_L  input  1  synchronous active-low reset.
REQ-004 in_valid  input  1  EX beat present on the input bus.
REQ-005 in_ready  output  1  stage accepts the beat this cycle.
REQ-006 BusW_in  input  64  ALU result.
REQ-007 Zero_in  input  1  ALU zero flag.
REQ-008 BusB_in  input  64  store data.
REQ-009 Rd_in  input  5  destination register.
REQ-010 MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in, Branch_in  input  1 each  EX control bits.
REQ-011 flush  input  1  squash all held and incoming beats.
REQ-012 out_valid  output  1  MEM beat present.
REQ-013 out_ready  input  1  MEM stage accepts the beat.
REQ-014 BusW_out, BusB_out, Rd_out, MemRead_out, MemWrite_out, MemtoReg_out, RegWrite_out  output  64/64/5/1/1/1/1  registered copies of the inputs.
REQ-015 PCSrc  output  1  registered Branch_in AND Zero_in, gated by out_valid.

Function
REQ-016 A beat SHALL transfer in on (in_valid & in_ready) and out on (out_valid & out_ready).
REQ-017 Data SHALL be in-order, with no drop (except on flush) and no duplication.
REQ-018 Output fields SHALL remain stable while out_valid & !out_ready.
REQ-019 Latency SHALL be 1 cycle: a beat accepted in cycle N appears with out_valid=1 in cycle N+1.
REQ-020 The state machine SHALL have three states:
- EMPTY: accept -> FULL.
- FULL: accept without drain -> SKID (macro on); drain without accept -> EMPTY; accept with drain -> FULL, with the new beat in the output register.
- SKID: drain -> FULL, with the skid beat promoted; no accept.
REQ-021 In FULL with simultaneous accept and drain, there SHALL be no bubble: the output updates with the new beat the next cycle.
REQ-022 flush=1 SHALL take priority over all other events: the next state is EMPTY, the same-cycle input beat is discarded, and out_valid=0 the next cycle.
REQ-023 Any output transfer occurring in the same cycle as flush SHALL still count as delivered.
REQ-024 PCSrc SHALL be 0 whenever out_valid=0.

Reset
REQ-025 While Reset_L=0 at a clock edge, the state SHALL go to EMPTY, and out_valid, PCSrc and all output fields SHALL go to 0.
REQ-026 in_ready SHALL be 0 during the reset cycle and 1 in the first cycle after Reset_L rises.
REQ-027 Reset mid-operation SHALL discard all held beats and SHALL produce no output transfer after the reset edge.

Configuration
REQ-028 With EX_MEM_SKID_EN defined, the stage SHALL include a 1-entry skid register and SKID state, and in_ready SHALL be registered as (state != SKID).
REQ-029 Without EX_MEM_SKID_EN, the SKID state and skid register SHALL be absent, and in_ready SHALL be combinational as (!out_valid | out_ready).
REQ-030 Observable ordering and latency SHALL be identical in both builds; only in_ready timing SHALL differ.

Structure
REQ-031 Package ex_mem_pkg SHALL hold:
- the state encoding (EMPTY=2'b00, FULL=2'b01, SKID=2'b10);
- the packed EX/MEM payload type (BusW, BusB, Rd, five control bits, Zero);
- width constants DATA_W=64 and REG_W=5.
REQ-032 One sub-module, ex_mem_payload_reg, SHALL implement the enable-loaded payload register and SHALL be instantiated for the output and skid entries.

Verification
REQ-033 Reset, then one beat BusW_in=64'h10, Rd_in=5, RegWrite_in=1, with out_ready=1 -> next cycle out_valid=1, BusW_out=64'h10, Rd_out=5, then out_valid=0.
REQ-034 Branch_in=1, Zero_in=1 -> PCSrc=1 one cycle later; Branch_in=1, Zero_in=0 -> PCSrc=0.
REQ-035 out_ready=0 for 3 cycles while 2 beats (A, B) are offered (macro on) -> A held stable on the output, B in skid, in_ready=0; release -> A then B on consecutive cycles.
REQ-036 Streaming 8 beats with out_ready=1 continuously -> 8 outputs in order, one per cycle, no bubbles.
REQ-037 flush while in SKID, with in_valid=1 -> out_valid=0 the next cycle and none of the three beats ever emitted.
REQ-038 Reset_L=0 asserted in FULL with out_ready=0 -> out_valid=0 and BusW_out=0 the next cycle, and in_ready=1 one cycle after release.
